// File: rtl/alu_8bit_if.sv
// Instruction/result bundle for the registered 8-bit ALU.
// ALU8_ZERO_FLAG_EN adds the registered zero flag.
interface alu_8bit_if;
  logic [17:0] instruction;
  logic [7:0]  out;
  logic [7:0]  extended_out;
  logic        overflow;
  logic        carry;
`ifdef ALU8_ZERO_FLAG_EN
  logic        zero;
`endif

  modport master (
    output instruction,
    input  out,
    input  extended_out,
    input  overflow,
    input  carry
`ifdef ALU8_ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  instruction,
    output out,
    output extended_out,
    output overflow,
    output carry
`ifdef ALU8_ZERO_FLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: ADD/AND/XOR/MUL, result one cycle after sampling.
// ALU8_ZERO_FLAG_EN adds a registered zero flag on the full 16-bit result.
module alu_8bit (
  input logic       clk,
  input logic       rst,
  alu_8bit_if.slave bus
);

  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [8:0]  sum;
  logic [15:0] prod;

  logic [7:0]  out_nxt;
  logic [7:0]  ext_nxt;
  logic        ovf_nxt;
  logic        cry_nxt;

  assign op   = bus.instruction[17:16];
  assign a    = bus.instruction[15:8];
  assign b    = bus.instruction[7:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {8'h00, a} * {8'h00, b};

  always_comb begin
    out_nxt = 8'h00;
    ext_nxt = 8'h00;
    ovf_nxt = 1'b0;
    cry_nxt = 1'b0;
    unique case (1'b1)
      (op == 2'b00): begin
        out_nxt = sum[7:0];
        cry_nxt = sum[8];
        ovf_nxt = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      (op == 2'b01): out_nxt = a & b;
      (op == 2'b10): out_nxt = a ^ b;
      (op == 2'b11): begin
        out_nxt = prod[7:0];
        ext_nxt = prod[15:8];
        ovf_nxt = |prod[15:8];
      end
      default: out_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out          <= 8'h00;
      bus.extended_out <= 8'h00;
      bus.overflow     <= 1'b0;
      bus.carry        <= 1'b0;
    end else begin
      bus.out          <= out_nxt;
      bus.extended_out <= ext_nxt;
      bus.overflow     <= ovf_nxt;
      bus.carry        <= cry_nxt;
    end
  end

`ifdef ALU8_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) bus.zero <= 1'b0;
    else     bus.zero <= ({ext_nxt, out_nxt} == 16'h0000);
  end
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed corner cases plus
// random instructions against an arithmetic reference model.
module tb_alu_8bit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_8bit_if bus ();

  alu_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference computed from the arithmetic meaning of each opcode.
  task automatic model(input logic [17:0] ins, input logic r,
                       output int o, output int e,
                       output int c, output int v);
    int op, a, b, sa, sb, s, p;
    op = int'(ins[17:16]);
    a  = int'(ins[15:8]);
    b  = int'(ins[7:0]);
    o = 0; e = 0; c = 0; v = 0;
    if (r) return;
    case (op)
      0: begin
        s  = a + b;
        o  = s % 256;
        c  = (s > 255) ? 1 : 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        v  = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
      end
      1: o = a & b;
      2: o = a ^ b;
      default: begin
        p = a * b;
        o = p % 256;
        e = p / 256;
        v = (p > 255) ? 1 : 0;
      end
    endcase
  endtask

  task automatic step(input logic [17:0] ins, input logic r, input string tag);
    int o, e, c, v;
    bus.instruction = ins;
    rst = r;
    model(ins, r, o, e, c, v);
    @(posedge clk);
    #1;
    check({tag, ".out"}, int'(bus.out), o);
    check({tag, ".ext"}, int'(bus.extended_out), e);
    check({tag, ".carry"}, int'(bus.carry), c);
    check({tag, ".ovf"}, int'(bus.overflow), v);
`ifdef ALU8_ZERO_FLAG_EN
    check({tag, ".zero"}, int'(bus.zero), (o == 0 && e == 0 && !r) ? 1 : 0);
`endif
  endtask

  function automatic logic [17:0] mk(input logic [1:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    return {op, a, b};
  endfunction

  logic [7:0] edge_vals [6];

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.instruction = 18'h3FFFF;
    edge_vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    step(18'h3FFFF, 1'b1, "rst0");
    step(mk(2'b00, 8'h80, 8'h80), 1'b1, "rst1");

    step(mk(2'b00, 8'h01, 8'h07), 1'b0, "add_1_7");
    step(mk(2'b01, 8'h14, 8'h0F), 1'b0, "and");
    step(mk(2'b11, 8'h03, 8'h07), 1'b0, "mul_3_7");
    step(mk(2'b11, 8'hFF, 8'hFF), 1'b0, "mul_ff");
    step(mk(2'b10, 8'h0F, 8'hF0), 1'b0, "xor");
    step(mk(2'b00, 8'hFF, 8'h01), 1'b0, "add_ff_1");
    step(mk(2'b00, 8'h7F, 8'h01), 1'b0, "add_7f_1");
    step(mk(2'b00, 8'h80, 8'h80), 1'b0, "add_80_80");
    step(mk(2'b01, 8'hF0, 8'h0F), 1'b0, "and_zero");
    step(mk(2'b11, 8'h00, 8'hFF), 1'b0, "mul_0");

    // back-to-back with a mid-stream reset
    step(mk(2'b11, 8'h10, 8'h10), 1'b0, "b2b0");
    step(mk(2'b11, 8'hC8, 8'h02), 1'b1, "b2b_rst");
    step(mk(2'b00, 8'h22, 8'h33), 1'b0, "b2b_resume");

    for (int i = 0; i < 300; i++) begin
      logic [17:0] ins;
      logic        r;
      ins = 18'($urandom);
      if ($urandom_range(3) == 0) begin
        ins[15:8] = edge_vals[$urandom_range(5)];
        ins[7:0]  = edge_vals[$urandom_range(5)];
      end
      r = ($urandom_range(19) == 0);
      step(ins, r, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
